// File: rtl/mlp_train_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mlp_train_monitor_pkg
// Brief   : Shared fixed-point type, thresholds, monitor state encoding and
//           saturating sfp helpers for the MLP training monitor.
// Revision: 1.0  initial release
// ============================================================================
package mlp_train_monitor_pkg;

    // Signed Q8.8 fixed point.
    typedef logic signed [15:0] sfp;

    localparam sfp HALF    = 16'sh0080;
    localparam sfp ONE     = 16'sh0100;
    localparam sfp SFP_MAX = 16'sh7FFF;
    localparam sfp SFP_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        TRAIN = 2'd0,
        CONV  = 2'd1,
        TMO   = 2'd2
    } monitor_state_e;

    // |a - b| computed one bit wider so extreme operands clamp instead of wrapping.
    function automatic sfp sfp_abs_diff(input sfp a, input sfp b);
        logic signed [16:0] d;
        d = 17'(a) - 17'(b);
        if (d < 0) d = -d;
        if (d > 17'sd32767) return SFP_MAX;
        return d[15:0];
    endfunction

    function automatic sfp sfp_abs(input sfp a);
        return sfp_abs_diff(a, '0);
    endfunction

    function automatic sfp sfp_add_sat(input sfp a, input sfp b);
        logic signed [16:0] s;
        s = 17'(a) + 17'(b);
        if (s > 17'sd32767) return SFP_MAX;
        if (s < -17'sd32768) return SFP_MIN;
        return s[15:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mlp_train_monitor_if.sv
`default_nettype none
// ============================================================================
// Module  : mlp_train_monitor_if
// Brief   : Sample/score bundle between the training driver (master) and the
//           training monitor (slave).
// Revision: 1.0  initial release
// ============================================================================
interface mlp_train_monitor_if #(
    parameter int OUTPUTS           = 1,
    parameter int SAMPLES_PER_EPOCH = 4,
    parameter int MAX_EPOCHS        = 10
) ();
    import mlp_train_monitor_pkg::*;

    logic                                   sample_valid;
    sfp [OUTPUTS-1:0]                       prediction;
    sfp [OUTPUTS-1:0]                       expected;
    logic                                   training_en;
    logic                                   score_valid;
    logic [$clog2(SAMPLES_PER_EPOCH+1)-1:0] epoch_correct;
    logic [$clog2(MAX_EPOCHS+1)-1:0]        epoch_count;
    logic                                   converged;
    logic                                   timeout;
    logic                                   output_led;
    sfp                                     epoch_abs_err;

    modport master (
        output sample_valid, prediction, expected,
        input  training_en, score_valid, epoch_correct, epoch_count,
               converged, timeout, output_led, epoch_abs_err
    );

    modport slave (
        input  sample_valid, prediction, expected,
        output training_en, score_valid, epoch_correct, epoch_count,
               converged, timeout, output_led, epoch_abs_err
    );

endinterface
`default_nettype wire

// File: rtl/mlp_train_monitor_sample_grader.sv
`default_nettype none
// ============================================================================
// Module  : mlp_sample_grader
// Brief   : Combinational per-sample grading: HALF-threshold agreement over all
//           outputs, plus summed |prediction-expected| when
//           MLP_MONITOR_ABS_ERR_EN is defined.
// Revision: 1.0  initial release
// ============================================================================
module mlp_sample_grader
    import mlp_train_monitor_pkg::*;
#(
    parameter int OUTPUTS = 1
) (
    input  sfp [OUTPUTS-1:0] i_prediction,
    input  sfp [OUTPUTS-1:0] i_expected,
    output logic             o_correct
`ifdef MLP_MONITOR_ABS_ERR_EN
    ,
    output sfp               o_abs_err
`endif
);

    always_comb begin
        o_correct = 1'b1;
`ifdef MLP_MONITOR_ABS_ERR_EN
        o_abs_err = '0;
`endif
        for (int i = 0; i < OUTPUTS; i++) begin
            // Strictly greater: a value sitting exactly on HALF grades as 0.
            if ((sfp'(i_prediction[i]) > HALF) != (sfp'(i_expected[i]) > HALF))
                o_correct = 1'b0;
`ifdef MLP_MONITOR_ABS_ERR_EN
            o_abs_err = sfp_add_sat(o_abs_err,
                                    sfp_abs_diff(sfp'(i_prediction[i]), sfp'(i_expected[i])));
`endif
        end
    end

endmodule
`default_nettype wire

// File: rtl/mlp_train_monitor.sv
`default_nettype none
// ============================================================================
// Module  : mlp_train_monitor
// Brief   : Per-epoch accuracy scoring and convergence/timeout decision for the
//           MLP training loop. Optional abs-error sum: MLP_MONITOR_ABS_ERR_EN.
// Revision: 1.0  initial release
// ============================================================================
module mlp_train_monitor
    import mlp_train_monitor_pkg::*;
#(
    parameter int OUTPUTS           = 1,
    parameter int SAMPLES_PER_EPOCH = 4,
    parameter int MAX_EPOCHS        = 10,
    parameter int CLEAN_EPOCHS      = 2
) (
    input  logic              clk,
    input  logic              rst,
    mlp_train_monitor_if.slave mon
);

    localparam int c_ec_w  = $clog2(SAMPLES_PER_EPOCH + 1);
    localparam int c_epc_w = $clog2(MAX_EPOCHS + 1);
    localparam int c_cr_w  = $clog2(CLEAN_EPOCHS + 1);

    localparam logic [c_ec_w-1:0]  c_last_idx = c_ec_w'(SAMPLES_PER_EPOCH - 1);
    localparam logic [c_ec_w-1:0]  c_full     = c_ec_w'(SAMPLES_PER_EPOCH);
    localparam logic [c_epc_w-1:0] c_max_ep   = c_epc_w'(MAX_EPOCHS);
    localparam logic [c_cr_w-1:0]  c_clean    = c_cr_w'(CLEAN_EPOCHS);

    monitor_state_e     r_state, w_state_next;
    logic [c_ec_w-1:0]  r_idx;
    logic [c_ec_w-1:0]  r_run_cnt, w_run_next;
    logic [c_ec_w-1:0]  r_epoch_correct;
    logic [c_cr_w-1:0]  r_clean_run, w_clean_next;
    logic [c_epc_w-1:0] r_epoch_count, w_epoch_count_next;
    logic               r_score_valid;
    logic               r_led;
    logic               w_correct;
    logic               w_scoring;
    logic               w_epoch_end;
`ifdef MLP_MONITOR_ABS_ERR_EN
    sfp                 w_sample_err;
    sfp                 r_abs_acc;
    sfp                 r_abs_err;
`endif

    mlp_sample_grader #(
        .OUTPUTS (OUTPUTS)
    ) u_grader (
        .i_prediction (mon.prediction),
        .i_expected   (mon.expected),
        .o_correct    (w_correct)
`ifdef MLP_MONITOR_ABS_ERR_EN
        ,
        .o_abs_err    (w_sample_err)
`endif
    );

    always_comb begin
        w_state_next       = r_state;
        w_scoring          = (r_state == TRAIN) && mon.sample_valid;
        w_epoch_end        = w_scoring && (r_idx == c_last_idx);
        w_run_next         = r_run_cnt + c_ec_w'(w_correct);
        w_clean_next       = (w_run_next == c_full) ? r_clean_run + c_cr_w'(1) : '0;
        w_epoch_count_next = r_epoch_count + c_epc_w'(1);
        // Convergence is tested first so it wins when both land on one epoch.
        if (w_epoch_end) begin
            if (w_clean_next == c_clean)
                w_state_next = CONV;
            else if (w_epoch_count_next == c_max_ep)
                w_state_next = TMO;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= TRAIN;
            r_idx           <= '0;
            r_run_cnt       <= '0;
            r_epoch_correct <= '0;
            r_clean_run     <= '0;
            r_epoch_count   <= '0;
            r_score_valid   <= 1'b0;
            r_led           <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_score_valid <= w_epoch_end;
            if (mon.sample_valid)
                r_led <= sfp'(mon.prediction[0]) > HALF;
            if (w_scoring) begin
                if (w_epoch_end) begin
                    r_idx           <= '0;
                    r_run_cnt       <= '0;
                    r_epoch_correct <= w_run_next;
                    r_clean_run     <= w_clean_next;
                    r_epoch_count   <= w_epoch_count_next;
                end else begin
                    r_idx     <= r_idx + c_ec_w'(1);
                    r_run_cnt <= w_run_next;
                end
            end
        end
    end

`ifdef MLP_MONITOR_ABS_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_abs_acc <= '0;
            r_abs_err <= '0;
        end else if (w_scoring) begin
            if (w_epoch_end) begin
                r_abs_err <= sfp_add_sat(r_abs_acc, w_sample_err);
                r_abs_acc <= '0;
            end else begin
                r_abs_acc <= sfp_add_sat(r_abs_acc, w_sample_err);
            end
        end
    end

    assign mon.epoch_abs_err = r_abs_err;
`else
    assign mon.epoch_abs_err = '0;
`endif

    assign mon.training_en   = (r_state == TRAIN);
    assign mon.converged     = (r_state == CONV);
    assign mon.timeout       = (r_state == TMO);
    assign mon.score_valid   = r_score_valid;
    assign mon.epoch_correct = r_epoch_correct;
    assign mon.epoch_count   = r_epoch_count;
    assign mon.output_led    = r_led;

endmodule
`default_nettype wire

// File: tb/tb_mlp_train_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_mlp_train_monitor
// Brief   : Randomized self-checking bench for mlp_train_monitor against an
//           epoch-history reference model (MLP_MONITOR_ABS_ERR_EN aware).
// Revision: 1.0  initial release
// ============================================================================
module tb_mlp_train_monitor;
    import mlp_train_monitor_pkg::*;

    localparam int OUTPUTS = 1;
    localparam int SPE     = 4;
    localparam int MAX_EP  = 10;
    localparam int CLEAN   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mlp_train_monitor_if #(.OUTPUTS(OUTPUTS), .SAMPLES_PER_EPOCH(SPE), .MAX_EPOCHS(MAX_EP)) mon ();

    mlp_train_monitor #(
        .OUTPUTS           (OUTPUTS),
        .SAMPLES_PER_EPOCH (SPE),
        .MAX_EPOCHS        (MAX_EP),
        .CLEAN_EPOCHS      (CLEAN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mon (mon)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: completed-epoch history plus the samples of the open epoch.
    bit m_conv, m_tmo, m_score, m_led;
    int m_epochs, m_ep_correct, m_abs_sum, m_abs_out;
    bit q_cur[$];
    bit hist[$];

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_conv = 0; m_tmo = 0; m_score = 0; m_led = 0;
        m_epochs = 0; m_ep_correct = 0; m_abs_sum = 0; m_abs_out = 0;
        q_cur.delete();
        hist.delete();
    endtask

    task automatic model_step(input bit v, input sfp p, input sfp e);
        int c;
        int run;
        int d;
        m_score = 0;
        if (v) m_led = (p > HALF);
        if (v && !m_conv && !m_tmo) begin
            q_cur.push_back((p > HALF) == (e > HALF));
            d = int'(p) - int'(e);
            m_abs_sum += (d < 0) ? -d : d;
            if (q_cur.size() == SPE) begin
                c = 0;
                foreach (q_cur[i]) c += int'(q_cur[i]);
                m_ep_correct = c;
                m_epochs++;
                m_score = 1;
                hist.push_back(c == SPE);
                q_cur.delete();
`ifdef MLP_MONITOR_ABS_ERR_EN
                m_abs_out = (m_abs_sum > 32767) ? 32767 : m_abs_sum;
`endif
                m_abs_sum = 0;
                run = 0;
                for (int i = hist.size() - 1; i >= 0 && hist[i]; i--) run++;
                if (run >= CLEAN)        m_conv = 1;
                else if (m_epochs >= MAX_EP) m_tmo = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("training_en",   mon.training_en,   !(m_conv || m_tmo));
        chk("score_valid",   mon.score_valid,   m_score);
        chk("converged",     mon.converged,     m_conv);
        chk("timeout",       mon.timeout,       m_tmo);
        chk("output_led",    mon.output_led,    m_led);
        chk("epoch_count",   mon.epoch_count,   m_epochs);
        chk("epoch_correct", mon.epoch_correct, m_ep_correct);
        chk("epoch_abs_err", mon.epoch_abs_err, m_abs_out);
    endtask

    task automatic send(input bit v, input sfp p, input sfp e);
        mon.sample_valid  = v;
        mon.prediction[0] = p;
        mon.expected[0]   = e;
        @(posedge clk);
        model_step(v, p, e);
        #1;
        check_all();
        mon.sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mon.sample_valid = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        check_all();
        rst = 1'b0;
    endtask

    // Value on the requested side of HALF, biased toward the threshold and rails.
    function automatic sfp rand_val(input bit above);
        case ($urandom_range(0, 5))
            0:       return above ? sfp'(int'(HALF) + 1) : HALF;
            1:       return above ? SFP_MAX : SFP_MIN;
            default: return above ? sfp'(int'(HALF) + 1 + int'($urandom_range(0, 2000)))
                                  : sfp'(int'(HALF) - int'($urandom_range(0, 2000)));
        endcase
    endfunction

    task automatic run_epoch(input int n_wrong);
        bit w[SPE];
        bit a;
        int cnt;
        int j;
        foreach (w[i]) w[i] = 0;
        cnt = 0;
        while (cnt < n_wrong) begin
            j = $urandom_range(0, SPE - 1);
            if (!w[j]) begin w[j] = 1; cnt++; end
        end
        for (int s = 0; s < SPE; s++) begin
            if ($urandom_range(0, 3) == 0)
                send(1'b0, rand_val(1'($urandom_range(0, 1))), rand_val(1'($urandom_range(0, 1))));
            a = 1'($urandom_range(0, 1));
            send(1'b1, rand_val(w[s] ? !a : a), rand_val(a));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mon.sample_valid = 1'b0;
        mon.prediction   = '0;
        mon.expected     = '0;
        do_reset();

        // Partial epoch discarded by reset.
        send(1'b1, ONE, ONE);
        send(1'b1, ONE, ONE);
        do_reset();
        run_epoch(0);
        chk("rst_score_valid",   mon.score_valid,   1);
        chk("rst_epoch_correct", mon.epoch_correct, 4);
        chk("rst_epoch_count",   mon.epoch_count,   1);

        // AND truth table twice converges.
        do_reset();
        for (int ep = 0; ep < 2; ep++) begin
            for (int s = 0; s < SPE; s++)
                send(1'b1, (s == 3) ? ONE : sfp'(0), (s == 3) ? ONE : sfp'(0));
        end
        chk("and_converged",   mon.converged,   1);
        chk("and_training_en", mon.training_en, 0);
        chk("and_epoch_count", mon.epoch_count, 2);

        // A wrong epoch breaks the clean run.
        do_reset();
        run_epoch(0); run_epoch(1); run_epoch(0); run_epoch(2); run_epoch(0); run_epoch(0);
        chk("run_converged",   mon.converged,   1);
        chk("run_epoch_count", mon.epoch_count, 6);

        // Timeout with one wrong sample per epoch, then frozen counters.
        do_reset();
        for (int ep = 0; ep < MAX_EP; ep++) run_epoch(1);
        chk("tmo_timeout",       mon.timeout,       1);
        chk("tmo_converged",     mon.converged,     0);
        chk("tmo_epoch_count",   mon.epoch_count,   10);
        chk("tmo_epoch_correct", mon.epoch_correct, 3);
        for (int k = 0; k < 6; k++) send(1'b1, ONE, ONE);
        chk("tmo_frozen_count",  mon.epoch_count,   10);

        // Convergence exactly on the last budgeted epoch.
        do_reset();
        for (int ep = 0; ep < MAX_EP - 2; ep++) run_epoch($urandom_range(1, SPE));
        run_epoch(0);
        run_epoch(0);
        chk("last_converged",   mon.converged,   1);
        chk("last_timeout",     mon.timeout,     0);
        chk("last_epoch_count", mon.epoch_count, 10);

        // LED threshold, still tracking in a terminal state.
        send(1'b1, HALF, sfp'(0));
        chk("led_half", mon.output_led, 0);
        send(1'b1, sfp'(int'(HALF) + 1), sfp'(0));
        chk("led_half_plus", mon.output_led, 1);
        send(1'b0, sfp'(0), sfp'(0));
        chk("led_hold", mon.output_led, 1);

        // Four samples each 0.25 off.
        do_reset();
        for (int s = 0; s < SPE; s++) send(1'b1, sfp'(int'(ONE) + 64), ONE);
`ifdef MLP_MONITOR_ABS_ERR_EN
        chk("abs_err_one", mon.epoch_abs_err, int'(ONE));
`else
        chk("abs_err_tied", mon.epoch_abs_err, 0);
`endif

        // Random soak.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int ep = 0; ep < 12; ep++)
                run_epoch(($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, SPE));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
